// File: rtl/vga_pattern_pipe.sv
// Test-pattern pixel stage: two-cycle pipeline from sync-generator timing to registered RGB.
// hsync/vsync travel through the same two stages so every output stays aligned.
module vga_pattern_pipe #(
  parameter int   H_ACTIVE    = 640,
  parameter int   V_ACTIVE    = 480,
  parameter int   BAR_W       = 80,
  parameter int   CHK_BIT     = 5,
  parameter int   SCROLL_STEP = 4,
  parameter logic SYNC_IDLE   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [1:0] mode,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic [7:0] frame_cnt
);
  localparam int             PXW      = $clog2(BAR_W);
  localparam logic [9:0]     H_END    = 10'(H_ACTIVE);
  localparam logic [9:0]     V_TICK   = 10'(V_ACTIVE);
  localparam logic [PXW-1:0] PX_LAST  = PXW'(BAR_W - 1);
  localparam logic [PXW:0]   STEP     = (PXW+1)'(SCROLL_STEP);
  localparam logic [PXW:0]   BAR_WRAP = (PXW+1)'(BAR_W);

  logic [1:0]     cur_mode;
  logic [PXW-1:0] scroll_px;
  logic [2:0]     scroll_bar;
  logic [PXW-1:0] bar_px;
  logic [2:0]     bar_idx;
  logic           line_ok;

  logic           line_start;
  logic           tick;
  logic           in_active;
  logic           pix_ok;
  logic [PXW-1:0] pix_px;
  logic [2:0]     pix_idx;
  logic [PXW:0]   scroll_sum;

  // Column position of the current input pixel; reloaded at each line start.
  always_comb begin
    line_start = (hpos == '0);
    tick       = line_start && (vpos == V_TICK);
    in_active  = (hpos < H_END);
    pix_ok     = line_start || line_ok;
    pix_px     = bar_px;
    pix_idx    = bar_idx;
    if (line_start) begin
      if (cur_mode == 2'd3) begin
        pix_px  = scroll_px;
        pix_idx = scroll_bar;
      end else begin
        pix_px  = '0;
        pix_idx = '0;
      end
    end
    scroll_sum = {1'b0, scroll_px} + STEP;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt  <= '0;
      cur_mode   <= '0;
      scroll_px  <= '0;
      scroll_bar <= '0;
    end else if (tick) begin
      frame_cnt <= frame_cnt + 8'd1;
      cur_mode  <= mode;
      if (scroll_sum >= BAR_WRAP) begin
        scroll_px  <= PXW'(scroll_sum - BAR_WRAP);
        scroll_bar <= scroll_bar + 3'd1;
      end else begin
        scroll_px <= scroll_sum[PXW-1:0];
      end
    end
  end

  // line_ok stays low after reset until a line start, so a partial line is blanked.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bar_px  <= '0;
      bar_idx <= '0;
      line_ok <= 1'b0;
    end else begin
      line_ok <= pix_ok;
      if (in_active) begin
        if (pix_px == PX_LAST) begin
          bar_px  <= '0;
          bar_idx <= pix_idx + 3'd1;
        end else begin
          bar_px  <= pix_px + PXW'(1);
          bar_idx <= pix_idx;
        end
      end
    end
  end

  logic       s1_valid;
  logic       s1_hs;
  logic       s1_vs;
  logic [2:0] s1_idx;
  logic [1:0] s1_mode;
  logic       s1_chk;
  logic [3:0] s1_hgrad;
  logic [3:0] s1_vgrad;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_hs    <= SYNC_IDLE;
      s1_vs    <= SYNC_IDLE;
      s1_idx   <= '0;
      s1_mode  <= '0;
      s1_chk   <= 1'b0;
      s1_hgrad <= '0;
      s1_vgrad <= '0;
    end else begin
      s1_valid <= display_on && pix_ok;
      s1_hs    <= hsync_in;
      s1_vs    <= vsync_in;
      s1_idx   <= pix_idx;
      s1_mode  <= cur_mode;
      s1_chk   <= hpos[CHK_BIT] ^ vpos[CHK_BIT];
      s1_hgrad <= hpos[8:5];
      s1_vgrad <= vpos[8:5];
    end
  end

  logic [2:0] bar_c;
  logic [3:0] r_next;
  logic [3:0] g_next;
  logic [3:0] b_next;

  always_comb begin
    bar_c  = 3'd7 - s1_idx;
    r_next = '0;
    g_next = '0;
    b_next = '0;
    if (s1_valid) begin
      case (s1_mode)
        2'd1: begin
          r_next = {4{s1_chk}};
          g_next = {4{s1_chk}};
          b_next = {4{s1_chk}};
        end
        2'd2: begin
          r_next = s1_hgrad;
          g_next = s1_vgrad;
          b_next = ~s1_hgrad;
        end
        default: begin
          r_next = {4{bar_c[2]}};
          g_next = {4{bar_c[1]}};
          b_next = {4{bar_c[0]}};
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r         <= '0;
      g         <= '0;
      b         <= '0;
      hsync_out <= SYNC_IDLE;
      vsync_out <= SYNC_IDLE;
    end else begin
      r         <= r_next;
      g         <= g_next;
      b         <= b_next;
      hsync_out <= s1_hs;
      vsync_out <= s1_vs;
    end
  end

endmodule

// File: tb/tb_vga_pattern_pipe.sv
// Bench for vga_pattern_pipe: directed timing vectors, an arithmetic reference model of the
// pattern rules, and a per-cycle compare of every output against the model delayed by two cycles.
`timescale 1ns/1ps
module tb_vga_pattern_pipe;
  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       hsync_in;
  logic       vsync_in;
  logic [1:0] mode;
  logic       hsync_out;
  logic       vsync_out;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;
  logic [7:0] frame_cnt;

  always #20 clk = ~clk;

  vga_pattern_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .mode       (mode),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .r          (r),
    .g          (g),
    .b          (b),
    .frame_cnt  (frame_cnt)
  );

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    bit          lit_en;
    logic [11:0] lit;
    int          h;
    int          v;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   last_rst_low = 1'b1;
  int   frame_exp = 0;

  int   m_mode = 0;
  int   m_ticks = 0;
  int   m_frame = 0;
  bit   m_line_ok = 1'b0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] want,
                       input int h, input int v);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s (h=%0d v=%0d): got %h, expected %h", name, h, v, act, want);
    end
  endtask

  // Colour of a displayed pixel straight from the pattern definitions.
  function automatic logic [11:0] model_rgb(input int h, input int v, input int md, input int ticks);
    int bar;
    int c;
    logic [3:0] hr;
    logic [3:0] vr;
    hr = 4'((h / 32) % 16);
    vr = 4'((v / 32) % 16);
    if (md == 1) return ((((h / 32) % 2) ^ ((v / 32) % 2)) != 0) ? 12'hFFF : 12'h000;
    if (md == 2) return {hr, vr, ~hr};
    if (md == 3) bar = ((h + (ticks * 4) % 640) % 640) / 80;
    else         bar = h / 80;
    c = 7 - bar;
    return {((c / 4) % 2 != 0) ? 4'hF : 4'h0,
            ((c / 2) % 2 != 0) ? 4'hF : 4'h0,
            (c % 2 != 0)       ? 4'hF : 4'h0};
  endfunction

  task automatic step(input int h, input int v, input bit on, input bit hs, input bit vs,
                      input int md, input bit rst, input bit le = 1'b0, input logic [11:0] lv = 12'h000);
    exp_t e;
    @(negedge clk);
    reset      = rst;
    hpos       = 10'(h);
    vpos       = 10'(v);
    display_on = on;
    hsync_in   = hs;
    vsync_in   = vs;
    mode       = 2'(md);
    e.h = h;
    e.v = v;
    e.lit_en = le;
    e.lit = lv;
    if (!rst) begin
      e.rgb = 12'h000;
      e.hs = 1'b1;
      e.vs = 1'b1;
      m_mode = 0;
      m_ticks = 0;
      m_frame = 0;
      m_line_ok = 1'b0;
    end else begin
      e.rgb = (on && (m_line_ok || h == 0)) ? model_rgb(h, v, m_mode, m_ticks) : 12'h000;
      e.hs = hs;
      e.vs = vs;
      if (h == 0) m_line_ok = 1'b1;
      if (h == 0 && v == 480) begin
        m_ticks++;
        m_mode = md;
        m_frame = (m_frame + 1) % 256;
      end
    end
    @(posedge clk);
    exp_q.push_back(e);
    last_rst_low = !rst;
    frame_exp = m_frame;
    #1;
  endtask

  task automatic sweep(input int v, input int md,
                       input int h0, input logic [11:0] l0, input int h1, input logic [11:0] l1,
                       input int h2, input logic [11:0] l2, input int h3, input logic [11:0] l3);
    for (int h = 0; h < 640; h++) begin
      bit le;
      logic [11:0] lv;
      le = (h == h0) || (h == h1) || (h == h2) || (h == h3);
      lv = (h == h0) ? l0 : (h == h1) ? l1 : (h == h2) ? l2 : l3;
      step(h, v, 1'b1, 1'b1, 1'b1, md, 1'b1, le, lv);
    end
    for (int h = 640; h < 656; h++)
      step(h, v, 1'b0, 1'($urandom), 1'($urandom), md, 1'b1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      if (last_rst_low) begin
        e.rgb = 12'h000;
        e.hs = 1'b1;
        e.vs = 1'b1;
      end
      check("rgb", {r, g, b}, e.rgb, e.h, e.v);
      check("hsync_out", 12'(hsync_out), 12'(e.hs), e.h, e.v);
      check("vsync_out", 12'(vsync_out), 12'(e.vs), e.h, e.v);
      check("frame_cnt", 12'(frame_cnt), 12'(frame_exp), e.h, e.v);
      if (e.lit_en) check("literal_rgb", {r, g, b}, e.lit, e.h, e.v);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; hpos = '0; vpos = '0; display_on = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; mode = 2'd0;

    // Reset held mid-line, then released mid-line: blank until the next line start.
    for (int i = 0; i < 3; i++) step(300 + i, 5, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    check("reset_rgb", {r, g, b}, 12'h000, 302, 5);
    check("reset_hsync", 12'(hsync_out), 12'h001, 302, 5);
    check("reset_vsync", 12'(vsync_out), 12'h001, 302, 5);
    check("reset_frame", 12'(frame_cnt), 12'h000, 302, 5);
    for (int h = 303; h <= 310; h++) step(h, 5, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    for (int h = 640; h <= 643; h++) step(h, 5, 1'b0, 1'b0, 1'b1, 0, 1'b1);

    // Colour bars on line 10.
    sweep(10, 0, 0, 12'hFFF, 80, 12'hFF0, 560, 12'h000, 639, 12'h000);

    // Checkerboard.
    step(0, 480, 1'b0, 1'b1, 1'b0, 1, 1'b1);
    check("frame_after_tick1", 12'(frame_cnt), 12'h001, 0, 480);
    step(31, 0, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 12'h000);
    step(32, 0, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 12'hFFF);
    step(32, 32, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 12'h000);
    step(700, 0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1, 12'h000);
    for (int i = 0; i < 20; i++)
      step($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'($urandom), 1'($urandom), 1, 1'b1);

    // Mode request changes mid-frame; bars persist until the tick.
    step(0, 480, 1'b0, 1'b1, 1'b1, 0, 1'b1);
    sweep(100, 2, 0, 12'hFFF, 80, 12'hFF0, 200, 12'hF0F, 639, 12'h000);
    check("frame_before_tick", 12'(frame_cnt), 12'h002, 0, 100);
    step(0, 480, 1'b0, 1'b1, 1'b1, 2, 1'b1);
    check("frame_after_tick3", 12'(frame_cnt), 12'h003, 0, 480);
    step(0, 0, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b1, 12'h00F);
    step(480, 96, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b1, 12'hF30);
    for (int i = 0; i < 20; i++)
      step($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'($urandom), 1'($urandom), 3, 1'b1);

    // Scrolling bars after 21 frames from reset: offset 84 px.
    step(100, 200, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    step(101, 200, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    for (int i = 0; i < 21; i++) step(0, 480, 1'b0, 1'($urandom), 1'($urandom), 3, 1'b1);
    check("frame_21", 12'(frame_cnt), 12'd21, 0, 480);
    sweep(0, 3, 0, 12'hFF0, 75, 12'hFF0, 76, 12'hF0F, 556, 12'hFFF);

    // Frame counter wrap.
    for (int i = 0; i < 234; i++) step(0, 480, 1'b0, 1'($urandom), 1'($urandom), 3, 1'b1);
    check("frame_255", 12'(frame_cnt), 12'd255, 0, 480);
    step(0, 480, 1'b0, 1'b1, 1'b0, 3, 1'b1);
    check("frame_wrap", 12'(frame_cnt), 12'd0, 0, 480);

    for (int i = 0; i < 3; i++) step(650 + i, 490, 1'b0, 1'($urandom), 1'($urandom), 3, 1'b1);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
